fifo2_rr_arbiter: RTL and testbench
===================================

FIFO2_RR_ARBITER -- requirements
Module: fifo2_rr_arbiter

Interface
REQ-001 SHALL have parameter: width, 8, data bits per requester.
REQ-002 SHALL have port: CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  synchronous active-high reset.
REQ-004 SHALL have port: REQ  input  4  per-requester enqueue request; bit i is requester i.
REQ-005 SHALL have port: D_IN  input  4*width  packed requester data; requester i occupies bits [i*width +: width].
REQ-006 SHALL have port: GNT  output  4  one-hot-or-zero grant; combinational in the same cycle as REQ.
REQ-007 SHALL have port: DEQ  input  1  consumer dequeue of head entry.
REQ-008 SHALL have port: D_OUT  output  width  head entry data; registered.
REQ-009 SHALL have port: SRC  output  2  requester index of head entry; registered.
REQ-010 SHALL have port: EMPTY_N  output  1  head entry valid.
REQ-011 SHALL have port: FULL_N  output  1  buffer has a free slot.
REQ-012 SHALL have port: OCC  output  2  occupancy 0..2.
REQ-013 SHALL have port: CLR  input  1  synchronous flush.
REQ-014 SHALL have port: ERR  output  1  sticky flag for DEQ while empty.

Function
REQ-015 SHALL hold a 2-entry buffer of {SRC, data}, in-order, head at D_OUT/SRC.
REQ-016 SHALL set accept = (OCC<2) or (OCC==2 and DEQ); GNT SHALL be all-zero when accept=0, CLR=1, or RST=1.
REQ-017 SHALL pick the winner round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4); first set REQ bit wins.
REQ-018 SHALL load ptr with the winner index on each grant edge; ptr SHALL hold otherwise.
REQ-019 SHALL enqueue granted D_IN slice and index at the next rising edge; the entry appears at D_OUT one cycle after grant when the buffer was empty (no bypass).
REQ-020 SHALL pop the head on DEQ when EMPTY_N=1; the second entry moves to head in the same edge.
REQ-021 SHALL, on simultaneous enqueue and dequeue, keep OCC unchanged and preserve order (OCC=1: new entry becomes head; OCC=2: old tail becomes head, new entry becomes tail).
REQ-022 SHALL ignore DEQ when EMPTY_N=0, leave state unchanged, and set ERR=1 at the next edge.
REQ-023 SHALL drive EMPTY_N = (OCC!=0) and FULL_N = (OCC!=2), both registered-state-derived with no combinational path from REQ or DEQ.
REQ-024 SHALL, on CLR, set OCC=0, ptr=3, and ERR=0 at the next edge; CLR SHALL override simultaneous REQ/DEQ.
REQ-025 SHALL leave D_OUT/SRC data registers unchanged by CLR; only validity is cleared.

Reset
REQ-026 SHALL, on RST=1 at a rising edge, set OCC=0, EMPTY_N=0, FULL_N=1, ERR=0, ptr=3, and D_OUT=0, SRC=0; RST SHALL override CLR, REQ, and DEQ.
REQ-027 SHALL drive GNT=0 while RST=1; after release, requester 0 has highest priority.
REQ-028 SHALL discard buffered entries on RST asserted mid-operation; no stale entry is presented after reset.

Verification
REQ-029 Reset then REQ=4'b1111, DEQ=0 for 3 cycles -> GNT=0001, then 0010, then 0000 with OCC=2 and FULL_N=0; D_OUT=D_IN0, SRC=0.
REQ-030 OCC=2, REQ=4'b0100, DEQ=1 -> GNT=0100 the same cycle; next cycle OCC=2, SRC=1, and tail=requester 2 data.
REQ-031 REQ=4'b1111, DEQ=1 held 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3; SRC sequence lags by 1 cycle.
REQ-032 Empty buffer, DEQ=1 -> OCC stays 0 and ERR=1 next cycle; then CLR=1 -> ERR=0.
REQ-033 OCC=2, CLR=1 with REQ=4'b0001 -> GNT=0000; next cycle OCC=0, EMPTY_N=0, and the next grant goes to requester 0.
REQ-034 RST asserted while OCC=1 and REQ=4'b1000 -> GNT=0000; next cycle EMPTY_N=0, D_OUT=0, ERR=0.

Source files
------------

// File: rtl/fifo2_rr_arbiter.sv
// fifo2_rr_arbiter
//   Four requesters compete round-robin for entry into a two-deep in-order
//   buffer. Each entry stores the winning requester's data slice and index.
//   The head entry is presented on registered outputs D_OUT/SRC.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   REQ      in   [3:0]        enqueue request per requester
//   D_IN     in   [4*width-1:0] requester i data at [i*width +: width]
//   GNT      out  [3:0]        one-hot-or-zero grant, combinational
//   DEQ      in   pop the head entry
//   D_OUT    out  [width-1:0]  head data (registered)
//   SRC      out  [1:0]        head requester index (registered)
//   EMPTY_N  out  head entry valid
//   FULL_N   out  a free slot exists
//   OCC      out  [1:0]        occupancy 0..2
//   CLR      in   synchronous flush (data registers keep their contents)
//   ERR      out  sticky flag: DEQ seen while empty
module fifo2_rr_arbiter #(
  parameter int width = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ,
  input  logic [4*width-1:0] D_IN,
  output logic [3:0]         GNT,
  input  logic               DEQ,
  output logic [width-1:0]   D_OUT,
  output logic [1:0]         SRC,
  output logic               EMPTY_N,
  output logic               FULL_N,
  output logic [1:0]         OCC,
  input  logic               CLR,
  output logic               ERR
);

  logic [1:0]       occ_q, occ_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [width-1:0] head_data_q, head_data_d;
  logic [1:0]       head_src_q, head_src_d;
  logic [width-1:0] tail_data_q, tail_data_d;
  logic [1:0]       tail_src_q, tail_src_d;

  logic             win_vld;
  logic [1:0]       win_idx;
  logic [width-1:0] win_data;
  logic             accept;
  logic             push;
  logic             pop;

  // Round-robin search starting one past the last winner.
  always_comb begin : rr_search
    logic [1:0] idx;
    win_vld = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!win_vld && REQ[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign win_data = D_IN[win_idx*width +: width];

  // A full buffer can still accept when the head leaves in the same edge.
  assign accept = (occ_q != 2'd2) || DEQ;
  assign push   = win_vld && accept && !CLR && !RST;
  assign pop    = DEQ && (occ_q != 2'd0) && !CLR;
  assign GNT    = push ? (4'b0001 << win_idx) : 4'b0000;

  always_comb begin
    occ_d       = occ_q;
    ptr_d       = push ? win_idx : ptr_q;
    err_d       = err_q | (DEQ && (occ_q == 2'd0));
    head_data_d = head_data_q;
    head_src_d  = head_src_q;
    tail_data_d = tail_data_q;
    tail_src_d  = tail_src_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_data_d = win_data;
          head_src_d  = win_idx;
          occ_d       = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = win_data;
          head_src_d  = win_idx;
        end else if (push) begin
          tail_data_d = win_data;
          tail_src_d  = win_idx;
          occ_d       = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_src_d  = tail_src_q;
          if (push) begin
            tail_data_d = win_data;
            tail_src_d  = win_idx;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase
    // Flush clears validity and arbitration history but keeps data contents.
    if (CLR) begin
      occ_d = 2'd0;
      ptr_d = 2'd3;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q       <= 2'd0;
      ptr_q       <= 2'd3;
      err_q       <= 1'b0;
      head_data_q <= '0;
      head_src_q  <= 2'd0;
    end else begin
      occ_q       <= occ_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      head_data_q <= head_data_d;
      head_src_q  <= head_src_d;
    end
  end

  // Tail contents are only meaningful while OCC==2, so they need no reset.
  always_ff @(posedge CLK) begin
    tail_data_q <= tail_data_d;
    tail_src_q  <= tail_src_d;
  end

  assign D_OUT   = head_data_q;
  assign SRC     = head_src_q;
  assign OCC     = occ_q;
  assign EMPTY_N = (occ_q != 2'd0);
  assign FULL_N  = (occ_q != 2'd2);
  assign ERR     = err_q;

endmodule

// File: tb/tb_fifo2_rr_arbiter.sv
// Directed bench for fifo2_rr_arbiter. Inputs change 1 time unit after a
// rising edge; the combinational grant is sampled 1 unit later and the
// registered outputs are sampled 1 unit after each edge.
module tb_fifo2_rr_arbiter;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [3:0]     REQ;
  logic [4*W-1:0] D_IN;
  logic [3:0]     GNT;
  logic           DEQ;
  logic [W-1:0]   D_OUT;
  logic [1:0]     SRC;
  logic           EMPTY_N;
  logic           FULL_N;
  logic [1:0]     OCC;
  logic           CLR;
  logic           ERR;

  int n_chk  = 0;
  int n_fail = 0;

  fifo2_rr_arbiter #(.width(W)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .D_IN(D_IN), .GNT(GNT), .DEQ(DEQ),
    .D_OUT(D_OUT), .SRC(SRC), .EMPTY_N(EMPTY_N), .FULL_N(FULL_N),
    .OCC(OCC), .CLR(CLR), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST  = 1'b1;
    REQ  = 4'b1111;
    DEQ  = 1'b0;
    CLR  = 1'b0;
    D_IN = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step();
    step();

    // Reset state; grant suppressed while RST is high.
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_occ", 32'(OCC), 32'd0);
    chk("rst_empty_n", 32'(EMPTY_N), 32'd0);
    chk("rst_full_n", 32'(FULL_N), 32'd1);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_dout", 32'(D_OUT), 32'h0);
    chk("rst_src", 32'(SRC), 32'd0);

    // Fill from reset with all requesting, no dequeue.
    RST = 1'b0;
    #1 chk("fill_gnt0", 32'(GNT), 32'b0001);
    step();
    chk("fill_occ1", 32'(OCC), 32'd1);
    chk("fill_empty_n1", 32'(EMPTY_N), 32'd1);
    chk("fill_dout1", 32'(D_OUT), 32'hA0);
    #1 chk("fill_gnt1", 32'(GNT), 32'b0010);
    step();
    chk("fill_occ2", 32'(OCC), 32'd2);
    chk("fill_full_n2", 32'(FULL_N), 32'd0);
    #1 chk("full_gnt", 32'(GNT), 32'b0000);
    chk("full_dout", 32'(D_OUT), 32'hA0);
    chk("full_src", 32'(SRC), 32'd0);

    // Full buffer: enqueue and dequeue in the same cycle.
    REQ = 4'b0100;
    DEQ = 1'b1;
    #1 chk("fulldeq_gnt", 32'(GNT), 32'b0100);
    step();
    chk("fulldeq_occ", 32'(OCC), 32'd2);
    chk("fulldeq_src", 32'(SRC), 32'd1);
    chk("fulldeq_dout", 32'(D_OUT), 32'hA1);
    REQ = 4'b0000;
    step();
    chk("drain_occ1", 32'(OCC), 32'd1);
    chk("drain_src_tail", 32'(SRC), 32'd2);
    chk("drain_dout_tail", 32'(D_OUT), 32'hA2);
    step();
    chk("drain_occ0", 32'(OCC), 32'd0);
    chk("drain_empty_n", 32'(EMPTY_N), 32'd0);
    chk("drain_err0", 32'(ERR), 32'd0);

    // Dequeue while empty sets the sticky error; CLR clears it.
    step();
    chk("underflow_occ", 32'(OCC), 32'd0);
    chk("underflow_err", 32'(ERR), 32'd1);
    DEQ = 1'b0;
    step();
    chk("underflow_err_sticky", 32'(ERR), 32'd1);
    CLR = 1'b1;
    step();
    chk("clr_err", 32'(ERR), 32'd0);
    CLR = 1'b0;

    // Fill with requesters 1 and 2 (pointer ends at 2), then flush.
    REQ = 4'b0110;
    #1 chk("pre_clr_gnt0", 32'(GNT), 32'b0010);
    step();
    #1 chk("pre_clr_gnt1", 32'(GNT), 32'b0100);
    step();
    chk("pre_clr_occ", 32'(OCC), 32'd2);
    CLR = 1'b1;
    REQ = 4'b0001;
    #1 chk("clr_gnt", 32'(GNT), 32'b0000);
    step();
    chk("clr_occ", 32'(OCC), 32'd0);
    chk("clr_empty_n", 32'(EMPTY_N), 32'd0);
    chk("clr_full_n", 32'(FULL_N), 32'd1);
    chk("clr_keeps_dout", 32'(D_OUT), 32'hA1);
    CLR = 1'b0;
    // Pointer was reloaded to 3: requester 0 beats requester 3.
    REQ = 4'b1001;
    #1 chk("post_clr_gnt", 32'(GNT), 32'b0001);
    step();
    chk("post_clr_occ", 32'(OCC), 32'd1);

    // Reset mid-operation discards the buffered entry.
    RST = 1'b1;
    REQ = 4'b1000;
    #1 chk("midrst_gnt", 32'(GNT), 32'b0000);
    step();
    chk("midrst_empty_n", 32'(EMPTY_N), 32'd0);
    chk("midrst_dout", 32'(D_OUT), 32'h0);
    chk("midrst_err", 32'(ERR), 32'd0);
    chk("midrst_occ", 32'(OCC), 32'd0);

    // Streaming: all requesting, continuous dequeue, 8 cycles from reset.
    RST = 1'b0;
    REQ = 4'b1111;
    DEQ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("stream_gnt%0d", i), 32'(GNT), 32'(4'b0001 << (i % 4)));
      step();
      chk($sformatf("stream_src%0d", i), 32'(SRC), 32'(i % 4));
      chk($sformatf("stream_dout%0d", i), 32'(D_OUT), 32'(8'hA0 + (i % 4)));
      chk($sformatf("stream_occ%0d", i), 32'(OCC), 32'd1);
    end
    // First streaming cycle dequeued an empty buffer.
    chk("stream_err", 32'(ERR), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
